fx3_slave_fifo_responder: RTL and testbench
===========================================

# fx3_slave_fifo_responder

Synthesizable emulator of the FX3 side of the 2-bit-address synchronous slave FIFO interface, used to close the loop on the FPGA master without silicon. It accepts the master's slcs/slwr/slrd/sloe/pktend/faddr strobes and drives flaga–flagd and read data. It exposes host-side observation ports: committed packets from the write socket and an incrementing pattern source for the read socket.

## Interface
- BUF_WORDS, 16: words per socket buffer (2..1024)
- WMARK, 4: partial-flag watermark in words (1..BUF_WORDS-1)
- DRAIN_CYCLES, 32: cycles a committed write buffer takes to empty (≥1)
- REFILL_CYCLES, 32: cycles before an empty read buffer is full again (≥1)

Ports:
- clk_100  in  1  clock
- reset_  in  1  reset, asynchronous, active-low
- slcs_  in  1  chip select, active low
- slwr_  in  1  write strobe, active low
- slrd_  in  1  read strobe, active low
- sloe_  in  1  output enable, active low
- pktend_  in  1  packet end, active low
- faddr  in  2  socket address: 00 = read (FX3→FPGA), 01 = write (FPGA→FX3)
- fdata_i  in  32  data from master
- fdata_o  out  32  read data to master
- fdata_oe  out  1  drive enable for fdata_o
- flaga  out  1  write socket ready (1 = not full)
- flagb  out  1  write socket partial (1 = below watermark)
- flagc  out  1  read socket ready (1 = data available)
- flagd  out  1  read socket partial (1 = more than WMARK words left)
- wr_data_valid / wr_data  out  1 / 32  each accepted write word, echoed
- pkt_done  out  1  one-cycle pulse on packet commit
- pkt_len  out  CW  committed word count, CW = $clog2(BUF_WORDS+1)
- overflow / underflow  out  1 / 1  sticky error flags

## Operation
- wr_hit = ~slcs_ & ~slwr_ & faddr==01; rd_hit = ~slcs_ & ~slrd_ & faddr==00; pe_hit = ~slcs_ & ~pktend_ & faddr==01.
- Write socket FSM W_FILL/W_DRAIN, wcount (CW bits).
  - W_FILL, wr_hit: wcount+1; echo on wr_data_valid/wr_data next edge.
  - Commit when wcount reaches BUF_WORDS, or on pe_hit (the same-cycle write word is included). pe_hit alone with wcount==0 commits a ZLP, pkt_len=0.
  - On commit: pkt_done pulses, pkt_len = final count, state goes to W_DRAIN with a down-counter loaded with DRAIN_CYCLES.
  - W_DRAIN: wr_hit/pe_hit are dropped and set overflow. When the counter expires, wcount=0 and state returns to W_FILL.
- Read socket FSM R_REFILL/R_AVAIL, rcount.
  - R_REFILL: counts REFILL_CYCLES, then rcount=BUF_WORDS and state goes to R_AVAIL.
  - R_AVAIL, rd_hit: issue pattern value, pattern+1, rcount-1. At 0, state goes to R_REFILL.
  - rd_hit in R_REFILL sets underflow, issues 32'h0, and leaves the pattern unchanged.
  - Pattern resets to 0 and persists across buffers.
- Only faddr qualifies a strobe, so a simultaneous slwr_ and slrd_ acts on one socket only.
- fdata_oe = ~slcs_ & ~sloe_ & faddr==00 (combinational).

## Timing
- Read latency is 2: a word issued at edge k appears on fdata_o after edge k+2. This uses a 2-stage data pipeline and is independent of sloe_.
- Write echo appears 1 cycle after acceptance. pkt_done is registered and fires 1 cycle after the commit edge.
- Flags are registered from the state/count registers. A write accepted at edge k that fills the buffer drops flaga at edge k+1. The master must therefore use flagb for back-to-back writes.
- flagb = W_FILL & wcount < BUF_WORDS-WMARK. flagd = R_AVAIL & rcount > WMARK.
- Reset values:
  - flaga..flagd = 0, fdata_o = 0, wr_data = 0.
  - wr_data_valid, pkt_done, pkt_len, overflow, underflow = 0.
  - Write FSM in W_FILL with wcount 0; read FSM in R_REFILL with a full countdown.
  - Flags rise 1 cycle after reset release (flaga, flagb).
- Reset mid-packet discards the partial packet and emits no pkt_done.
- Sticky errors clear only on reset.

## Structure
- slave_fifo_pkg: ADDR_READ=2'b00, ADDR_WRITE=2'b01, the write/read state enums, and the transfer-mode codes (PARTIAL..LOOPBACK) shared with the master.
- Sub-module fx3_wr_socket holds the write FSM, commit logic and drain counter. The read socket, pattern counter and pipeline stay in the top.

## Test plan
- Reset release, BUF_WORDS=16: flaga=flagb=1 at cycle 1; flagc=1 after 32+1 cycles.
- 16 back-to-back writes 0..15: pkt_done with pkt_len=16; flaga=0 for 32 cycles; a 17th write sets overflow.
- 5 writes, then pktend with a 6th write: pkt_len=6. A lone pktend in W_FILL with wcount 0 gives pkt_len=0 (ZLP).
- 16 reads with sloe_ low: fdata_o = 0..15, each 2 cycles after its strobe. flagd falls when rcount ≤ 4, flagc falls after the last read, and the next buffer starts at 16.
- Read during R_REFILL: underflow=1, fdata_o=0, next valid read returns the unchanged pattern.
- Assert reset_ after 7 writes: no pkt_done, and all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/slave_fifo_pkg.sv
// rtl/slave_fifo_pkg.sv - shared socket addresses, FSM state types and transfer modes for the FX3 slave FIFO
package slave_fifo_pkg;

    localparam logic [1:0] ADDR_READ  = 2'b00;
    localparam logic [1:0] ADDR_WRITE = 2'b01;

    typedef enum logic { W_FILL, W_DRAIN } wr_state_t;
    typedef enum logic { R_REFILL, R_AVAIL } rd_state_t;

    typedef enum logic [2:0] {
        MODE_PARTIAL,
        MODE_ZLP,
        MODE_STREAM_IN,
        MODE_STREAM_OUT,
        MODE_LOOPBACK
    } xfer_mode_t;

    // A strobe counts only when the chip is selected and the socket address matches.
    function automatic logic strobe_hit(input logic cs_n, input logic strobe_n,
                                        input logic [1:0] faddr, input logic [1:0] want);
        return ~cs_n & ~strobe_n & (faddr == want);
    endfunction

endpackage

// File: rtl/fx3_slave_fifo_responder_if.sv
// rtl/fx3_slave_fifo_responder_if.sv - slave FIFO bus between the FPGA master and the FX3 responder
interface fx3_slave_fifo_responder_if;

    logic        slcs_;
    logic        slwr_;
    logic        slrd_;
    logic        sloe_;
    logic        pktend_;
    logic [1:0]  faddr;
    logic [31:0] fdata_i;
    logic [31:0] fdata_o;
    logic        fdata_oe;
    logic        flaga;
    logic        flagb;
    logic        flagc;
    logic        flagd;

    modport master (
        output slcs_, slwr_, slrd_, sloe_, pktend_, faddr, fdata_i,
        input  fdata_o, fdata_oe, flaga, flagb, flagc, flagd
    );

    modport slave (
        input  slcs_, slwr_, slrd_, sloe_, pktend_, faddr, fdata_i,
        output fdata_o, fdata_oe, flaga, flagb, flagc, flagd
    );

endinterface

// File: rtl/fx3_wr_socket.sv
// rtl/fx3_wr_socket.sv - FX3 write socket: fill/commit/drain FSM with word echo and packet report
module fx3_wr_socket
    import slave_fifo_pkg::*;
#(
    parameter  int BUF_WORDS    = 16,
    parameter  int WMARK        = 4,
    parameter  int DRAIN_CYCLES = 32,
    localparam int CW           = $clog2(BUF_WORDS + 1)
) (
    input  logic          clk_100,
    input  logic          reset_,
    input  logic          wr_hit,
    input  logic          pe_hit,
    input  logic [31:0]   wr_word,
    output logic          flaga,
    output logic          flagb,
    output logic          wr_data_valid,
    output logic [31:0]   wr_data,
    output logic          pkt_done,
    output logic [CW-1:0] pkt_len,
    output logic          overflow
);

    localparam int            DW            = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] FULL          = CW'(BUF_WORDS);
    localparam logic [CW-1:0] PARTIAL_LIMIT = CW'(BUF_WORDS - WMARK);

    wr_state_t     state, state_n;
    logic [CW-1:0] wcount, wcount_n, final_len;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          accept, commit, drop;
    logic          hold_v;
    logic [31:0]   hold_d;
    logic          commit_q;
    logic [CW-1:0] len_q;

    // Socket state, word count and drain countdown.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state  <= W_FILL;
            wcount <= '0;
            dcnt   <= '0;
        end else begin
            state  <= state_n;
            wcount <= wcount_n;
            dcnt   <= dcnt_n;
        end
    end

    // Fill until full or pktend (same-cycle word included), then hold off the master while draining.
    always_comb begin
        state_n   = state;
        wcount_n  = wcount;
        dcnt_n    = dcnt;
        final_len = wcount;
        accept    = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;
        case (state)
            W_FILL: begin
                if (wr_hit) begin
                    accept    = 1'b1;
                    final_len = wcount + 1'b1;
                end
                wcount_n = final_len;
                if (pe_hit || final_len == FULL) begin
                    commit  = 1'b1;
                    state_n = W_DRAIN;
                    dcnt_n  = DW'(DRAIN_CYCLES - 1);
                end
            end
            W_DRAIN: begin
                drop = wr_hit | pe_hit;
                if (dcnt == '0) begin
                    state_n  = W_FILL;
                    wcount_n = '0;
                end else begin
                    dcnt_n = dcnt - 1'b1;
                end
            end
        endcase
    end

    // Echo and packet report go through one holding stage so they land a cycle after the accepting edge.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            hold_v        <= 1'b0;
            hold_d        <= '0;
            wr_data_valid <= 1'b0;
            wr_data       <= '0;
            commit_q      <= 1'b0;
            len_q         <= '0;
            pkt_done      <= 1'b0;
            pkt_len       <= '0;
            flaga         <= 1'b0;
            flagb         <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            hold_v        <= accept;
            if (accept) hold_d <= wr_word;
            wr_data_valid <= hold_v;
            if (hold_v) wr_data <= hold_d;
            commit_q      <= commit;
            if (commit) len_q <= final_len;
            pkt_done      <= commit_q;
            if (commit_q) pkt_len <= len_q;
            flaga         <= (state == W_FILL);
            flagb         <= (state == W_FILL) && (wcount < PARTIAL_LIMIT);
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// rtl/fx3_slave_fifo_responder.sv - FX3 side of the 2-bit-address synchronous slave FIFO for closed-loop tests
module fx3_slave_fifo_responder
    import slave_fifo_pkg::*;
#(
    parameter  int BUF_WORDS     = 16,
    parameter  int WMARK         = 4,
    parameter  int DRAIN_CYCLES  = 32,
    parameter  int REFILL_CYCLES = 32,
    localparam int CW            = $clog2(BUF_WORDS + 1)
) (
    input  logic                     clk_100,
    input  logic                     reset_,
    fx3_slave_fifo_responder_if.slave bus,
    output logic                     wr_data_valid,
    output logic [31:0]              wr_data,
    output logic                     pkt_done,
    output logic [CW-1:0]            pkt_len,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int            RW   = $clog2(REFILL_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_WORDS);

    logic          wr_hit, rd_hit, pe_hit;
    logic          flaga_w, flagb_w;
    rd_state_t     rstate, rstate_n;
    logic [CW-1:0] rcount, rcount_n;
    logic [RW-1:0] rtimer, rtimer_n;
    logic [31:0]   pattern, pattern_n, issue_val;
    logic          issue, starve;
    logic [31:0]   issue_q, pipe_q, fdata_q;
    logic          flagc_q, flagd_q;

    assign wr_hit = strobe_hit(bus.slcs_, bus.slwr_,   bus.faddr, ADDR_WRITE);
    assign pe_hit = strobe_hit(bus.slcs_, bus.pktend_, bus.faddr, ADDR_WRITE);
    assign rd_hit = strobe_hit(bus.slcs_, bus.slrd_,   bus.faddr, ADDR_READ);

    assign bus.fdata_oe = strobe_hit(bus.slcs_, bus.sloe_, bus.faddr, ADDR_READ);
    assign bus.fdata_o  = fdata_q;
    assign bus.flaga    = flaga_w;
    assign bus.flagb    = flagb_w;
    assign bus.flagc    = flagc_q;
    assign bus.flagd    = flagd_q;

    fx3_wr_socket #(
        .BUF_WORDS    (BUF_WORDS),
        .WMARK        (WMARK),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_wr_socket (
        .clk_100       (clk_100),
        .reset_        (reset_),
        .wr_hit        (wr_hit),
        .pe_hit        (pe_hit),
        .wr_word       (bus.fdata_i),
        .flaga         (flaga_w),
        .flagb         (flagb_w),
        .wr_data_valid (wr_data_valid),
        .wr_data       (wr_data),
        .pkt_done      (pkt_done),
        .pkt_len       (pkt_len),
        .overflow      (overflow)
    );

    // Read socket state, remaining words, refill countdown and the free-running pattern.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            rstate  <= R_REFILL;
            rcount  <= '0;
            rtimer  <= RW'(REFILL_CYCLES - 1);
            pattern <= '0;
        end else begin
            rstate  <= rstate_n;
            rcount  <= rcount_n;
            rtimer  <= rtimer_n;
            pattern <= pattern_n;
        end
    end

    // Serve pattern words while a buffer is available; a read while refilling returns zero and is flagged.
    always_comb begin
        rstate_n  = rstate;
        rcount_n  = rcount;
        rtimer_n  = rtimer;
        pattern_n = pattern;
        issue     = 1'b0;
        issue_val = '0;
        starve    = 1'b0;
        case (rstate)
            R_REFILL: begin
                if (rd_hit) begin
                    issue  = 1'b1;
                    starve = 1'b1;
                end
                if (rtimer == '0) begin
                    rstate_n = R_AVAIL;
                    rcount_n = FULL;
                end else begin
                    rtimer_n = rtimer - 1'b1;
                end
            end
            R_AVAIL: begin
                if (rd_hit) begin
                    issue     = 1'b1;
                    issue_val = pattern;
                    pattern_n = pattern + 32'd1;
                    rcount_n  = rcount - 1'b1;
                    if (rcount == CW'(1)) begin
                        rstate_n = R_REFILL;
                        rtimer_n = RW'(REFILL_CYCLES - 1);
                    end
                end
            end
        endcase
    end

    // Issue register plus two pipeline stages; fdata_o shows the word two edges after it was issued.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            issue_q   <= '0;
            pipe_q    <= '0;
            fdata_q   <= '0;
            flagc_q   <= 1'b0;
            flagd_q   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (issue) issue_q <= issue_val;
            pipe_q    <= issue_q;
            fdata_q   <= pipe_q;
            flagc_q   <= (rstate == R_AVAIL);
            flagd_q   <= (rstate == R_AVAIL) && (rcount > CW'(WMARK));
            if (starve) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// tb/tb_fx3_slave_fifo_responder.sv - scoreboard bench for the FX3 slave FIFO responder
module tb_fx3_slave_fifo_responder;

    localparam int BUF_WORDS     = 16;
    localparam int WMARK         = 4;
    localparam int DRAIN_CYCLES  = 32;
    localparam int REFILL_CYCLES = 32;
    localparam int CW            = $clog2(BUF_WORDS + 1);

    logic          clk_100 = 1'b0;
    logic          reset_  = 1'b0;
    logic          wr_data_valid;
    logic [31:0]   wr_data;
    logic          pkt_done;
    logic [CW-1:0] pkt_len;
    logic          overflow;
    logic          underflow;

    fx3_slave_fifo_responder_if bus ();

    fx3_slave_fifo_responder #(
        .BUF_WORDS     (BUF_WORDS),
        .WMARK         (WMARK),
        .DRAIN_CYCLES  (DRAIN_CYCLES),
        .REFILL_CYCLES (REFILL_CYCLES)
    ) dut (
        .clk_100       (clk_100),
        .reset_        (reset_),
        .bus           (bus),
        .wr_data_valid (wr_data_valid),
        .wr_data       (wr_data),
        .pkt_done      (pkt_done),
        .pkt_len       (pkt_len),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t echo_q[$];
    exp_t pkt_q[$];
    exp_t rd_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: socket occupancy tracked with deadlines (edge numbers) rather than counters.
    bit          m_wfill;
    int          m_wcount;
    int          m_drain_end;
    bit          m_ravail;
    int          m_rleft;
    int          m_ready;
    logic [31:0] m_pat;
    bit          m_ovf;
    bit          m_udf;
    logic [3:0]  exp_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    task automatic model_init();
        m_wfill     = 1'b1;
        m_wcount    = 0;
        m_drain_end = -1;
        m_ravail    = 1'b0;
        m_rleft     = 0;
        m_ready     = REFILL_CYCLES;
        m_pat       = '0;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        exp_flags   = 4'b0000;
        echo_q.delete();
        pkt_q.delete();
        rd_q.delete();
    endtask

    // Apply one clock edge e of the specified behaviour to the model and queue the expected responses.
    task automatic model_edge(input int e, input bit wh, input bit ph, input bit rh, input logic [31:0] d);
        if (m_wfill) begin
            if (wh) begin
                m_wcount++;
                echo_q.push_back('{e + 1, d});
            end
            if (ph || m_wcount == BUF_WORDS) begin
                pkt_q.push_back('{e + 1, 32'(m_wcount)});
                m_wfill     = 1'b0;
                m_drain_end = e + DRAIN_CYCLES;
            end
        end else begin
            if (wh || ph) m_ovf = 1'b1;
            if (e == m_drain_end) begin
                m_wfill  = 1'b1;
                m_wcount = 0;
            end
        end
        if (m_ravail) begin
            if (rh) begin
                rd_q.push_back('{e + 2, m_pat});
                m_pat = m_pat + 1;
                m_rleft--;
                if (m_rleft == 0) begin
                    m_ravail = 1'b0;
                    m_ready  = e + REFILL_CYCLES;
                end
            end
        end else begin
            if (rh) begin
                m_udf = 1'b1;
                rd_q.push_back('{e + 2, 32'h0});
            end
            if (e == m_ready) begin
                m_ravail = 1'b1;
                m_rleft  = BUF_WORDS;
            end
        end
    endtask

    task automatic check_reset_values();
        check("rst_flags", {bus.flaga, bus.flagb, bus.flagc, bus.flagd}, 4'b0000);
        check("rst_fdata_o", bus.fdata_o, 32'h0);
        check("rst_fdata_oe", bus.fdata_oe, 1'b0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_wr_data_valid", wr_data_valid, 1'b0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_underflow", underflow, 1'b0);
    endtask

    // One cycle: check held outputs at the negedge, drive the next inputs, advance to the next negedge.
    task automatic step(input logic cs, input logic wr, input logic rd, input logic oe,
                        input logic pe, input logic [1:0] fa, input logic [31:0] d);
        bit wh, ph, rh;
        check("flags", {bus.flaga, bus.flagb, bus.flagc, bus.flagd}, exp_flags);
        check("fdata_oe", bus.fdata_oe, ~bus.slcs_ & ~bus.sloe_ & (bus.faddr == 2'b00));
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
        exp_flags = {m_wfill, m_wfill && (m_wcount < BUF_WORDS - WMARK),
                     m_ravail, m_ravail && (m_rleft > WMARK)};
        bus.slcs_   = cs;
        bus.slwr_   = wr;
        bus.slrd_   = rd;
        bus.sloe_   = oe;
        bus.pktend_ = pe;
        bus.faddr   = fa;
        bus.fdata_i = d;
        wh = !cs && !wr && (fa == 2'b01);
        ph = !cs && !pe && (fa == 2'b01);
        rh = !cs && !rd && (fa == 2'b00);
        model_edge(cyc + 1, wh, ph, rh, d);
        @(posedge clk_100);
        cyc++;
        @(negedge clk_100);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 32'h0);
    endtask

    // Monitor: pop and compare whenever the DUT presents an echo, a packet commit or a due read word.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_100);
            if (reset_) begin
                if (wr_data_valid) begin
                    if (echo_q.size() == 0) begin
                        check("echo_unexpected", wr_data_valid, 1'b0);
                    end else begin
                        e = echo_q.pop_front();
                        check("echo_cycle", cyc, e.due);
                        check("echo_data", wr_data, e.val);
                    end
                end else if (echo_q.size() > 0 && echo_q[0].due <= cyc) begin
                    e = echo_q.pop_front();
                    check("echo_missing", wr_data_valid, 1'b1);
                end
                if (pkt_done) begin
                    if (pkt_q.size() == 0) begin
                        check("pkt_unexpected", pkt_done, 1'b0);
                    end else begin
                        e = pkt_q.pop_front();
                        check("pkt_cycle", cyc, e.due);
                        check("pkt_len", pkt_len, e.val);
                    end
                end else if (pkt_q.size() > 0 && pkt_q[0].due <= cyc) begin
                    e = pkt_q.pop_front();
                    check("pkt_missing", pkt_done, 1'b1);
                end
                while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.due);
                    if (e.due == cyc) check("rd_data", bus.fdata_o, e.val);
                end
            end
        end
    end

    // Stimulus: directed test-plan sequences, then randomized traffic, then an async reset mid-packet.
    initial begin : driver
        bus.slcs_   = 1'b1;
        bus.slwr_   = 1'b1;
        bus.slrd_   = 1'b1;
        bus.sloe_   = 1'b1;
        bus.pktend_ = 1'b1;
        bus.faddr   = 2'b11;
        bus.fdata_i = '0;
        model_init();
        repeat (3) @(negedge clk_100);
        check_reset_values();
        reset_ = 1'b1;
        cyc    = 0;

        // Flags after release, read buffer becomes available after the refill time.
        idle(REFILL_CYCLES + 3);

        // Full packet of 16 back-to-back writes, then a write during drain.
        for (int i = 0; i < BUF_WORDS; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'(i));
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'hdead_beef);
        idle(DRAIN_CYCLES + 2);

        // Short packet ended by pktend together with the sixth word, then a lone ZLP.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h100 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 32'h105);
        idle(DRAIN_CYCLES + 2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 32'h0);
        idle(DRAIN_CYCLES + 2);

        // Drain a full read buffer, read while refilling, then read the next buffer's first word.
        for (int i = 0; i < BUF_WORDS; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
        idle(REFILL_CYCLES + 2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
        idle(4);

        // Randomized traffic across both sockets, including overlapping strobes.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] fa;
            fa = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) != 0), fa, $urandom);
        end
        idle(DRAIN_CYCLES + 4);

        // Seven writes, then reset asserted between edges: partial packet dropped, outputs clear at once.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 32'h700 + 32'(i));
        #2;
        bus.slcs_ = 1'b1;
        bus.slwr_ = 1'b1;
        bus.faddr = 2'b11;
        reset_    = 1'b0;
        #1;
        check_reset_values();
        model_init();
        repeat (3) @(negedge clk_100);
        reset_ = 1'b1;
        cyc    = 0;
        idle(REFILL_CYCLES + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
